// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_ctrl_if;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       iord_sel;
  logic       alusrca_sel;
  logic [1:0] alusrcb_sel;
  logic       memtoreg_sel;
  logic       regdst_sel;
  logic [1:0] pcsrc_sel;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       illegal_op;
  logic       idle;

  modport master (
    input  run, opcode, mem_ready,
    output iord_sel, alusrca_sel, alusrcb_sel, memtoreg_sel, regdst_sel,
           pcsrc_sel, alu_op, pc_write, pc_write_cond, ir_write, reg_write,
           mem_read, mem_write, illegal_op, idle
  );

  modport slave (
    output run, opcode, mem_ready,
    input  iord_sel, alusrca_sel, alusrcb_sel, memtoreg_sel, regdst_sel,
           pcsrc_sel, alu_op, pc_write, pc_write_cond, ir_write, reg_write,
           mem_read, mem_write, illegal_op, idle
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, stalling on the unified-memory ready handshake.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic              clk,
  input  logic              reset_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       idle;
  } ctrl_t;

  state_t state;
  state_t next_state;
  state_t boundary;
  ctrl_t  ctrl_q;
  logic   fetch_go;
  logic   opcode_legal;

  // Purely state-decoded controls; anything qualified by mem_ready or opcode is handled separately.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE:    c.idle = 1'b1;
      FETCH:   begin c.mem_read = 1'b1; c.alusrcb = 2'd1; end
      DECODE:  c.alusrcb = 2'd3;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'd2; end
      MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:   begin c.reg_write = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC:    begin c.alusrca = 1'b1; c.alu_op = 2'd2; end
      RWB:     begin c.reg_write = 1'b1; c.regdst = 1'b1; end
      BRANCH:  begin
        c.alusrca       = 1'b1;
        c.alu_op        = 2'd1;
        c.pcsrc         = 2'd1;
        c.pc_write_cond = 1'b1;
      end
      JUMP:    begin c.pcsrc = 2'd2; c.pc_write = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'd2; end
      ADDIWB:  c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    opcode_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                   (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                   (bus.opcode == OP_J)     || (bus.opcode == OP_ADDI);
  end

  // Every return to FETCH is an instruction boundary where run decides whether to keep going.
  always_comb begin
    boundary   = bus.run ? FETCH : IDLE;
    next_state = state;
    case (state)
      IDLE:   if (bus.run) next_state = FETCH;
      FETCH:  if (bus.mem_ready) next_state = DECODE;
      DECODE: begin
        if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) next_state = MEMADR;
        else if (bus.opcode == OP_RTYPE)                    next_state = EXEC;
        else if (bus.opcode == OP_BEQ)                      next_state = BRANCH;
        else if (bus.opcode == OP_J)                        next_state = JUMP;
        else if (bus.opcode == OP_ADDI)                     next_state = ADDIEX;
        else                                                next_state = boundary;
      end
      MEMADR: next_state = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) next_state = MEMWB;
      MEMWB:  next_state = boundary;
      MEMWR:  if (bus.mem_ready) next_state = boundary;
      EXEC:   next_state = RWB;
      RWB:    next_state = boundary;
      BRANCH: next_state = boundary;
      JUMP:   next_state = boundary;
      ADDIEX: next_state = ADDIWB;
      ADDIWB: next_state = boundary;
      default: next_state = IDLE;
    endcase
  end

  // Output register is loaded with the decode of the state being entered, so it always matches state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ctrl_q <= decode(IDLE);
    end else begin
      state  <= next_state;
      ctrl_q <= decode(next_state);
    end
  end

  assign fetch_go = (state == FETCH) && bus.mem_ready;

  assign bus.iord_sel      = ctrl_q.iord;
  assign bus.alusrca_sel   = ctrl_q.alusrca;
  assign bus.alusrcb_sel   = ctrl_q.alusrcb;
  assign bus.memtoreg_sel  = ctrl_q.memtoreg;
  assign bus.regdst_sel    = ctrl_q.regdst;
  assign bus.pcsrc_sel     = ctrl_q.pcsrc;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.pc_write      = ctrl_q.pc_write | fetch_go;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.ir_write      = fetch_go;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.illegal_op    = (state == DECODE) && !opcode_legal;
  assign bus.idle          = ctrl_q.idle;

  // The shared memory port can never see a read and a write together.
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n)
                               !(bus.mem_read && bus.mem_write));
  a_irw_in_fetch: assert property (@(posedge clk) disable iff (!reset_n)
                                   bus.ir_write |-> bus.mem_read);
  a_illegal_in_decode: assert property (@(posedge clk) disable iff (!reset_n)
                                        bus.illegal_op |-> (state == DECODE));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues the hand-derived
// control vector, and a negedge monitor pops and compares it against the DUT.
module tb_multicycle_ctrl;

  logic clk;
  logic reset_n;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(
    input logic       iord, alusrca,
    input logic [1:0] alusrcb,
    input logic       memtoreg, regdst,
    input logic [1:0] pcsrc, aluop,
    input logic       pcw, pcwc, irw, rw, mr, mw, ill, idl
  );
    return {iord, alusrca, alusrcb, memtoreg, regdst, pcsrc, aluop,
            pcw, pcwc, irw, rw, mr, mw, ill, idl};
  endfunction

  //                                   iord a  b     m2r rd pcs   aop   pcw pcwc irw rw mr mw ill idl
  localparam logic [17:0] E_IDLE       = mk(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1);
  localparam logic [17:0] E_FETCH_WAIT = mk(0, 0, 2'd1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
  localparam logic [17:0] E_FETCH_GO   = mk(0, 0, 2'd1, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 1, 0, 0, 0);
  localparam logic [17:0] E_DECODE     = mk(0, 0, 2'd3, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [17:0] E_DECODE_ILL = mk(0, 0, 2'd3, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0);
  localparam logic [17:0] E_MEMADR     = mk(0, 1, 2'd2, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [17:0] E_MEMRD      = mk(1, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
  localparam logic [17:0] E_MEMWB      = mk(0, 0, 2'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [17:0] E_MEMWR      = mk(1, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0);
  localparam logic [17:0] E_EXEC       = mk(0, 1, 2'd0, 0, 0, 2'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [17:0] E_RWB        = mk(0, 0, 2'd0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [17:0] E_BRANCH     = mk(0, 1, 2'd0, 0, 0, 2'd1, 2'd1, 0, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [17:0] E_JUMP       = mk(0, 0, 2'd0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [17:0] E_ADDIEX     = mk(0, 1, 2'd2, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [17:0] E_ADDIWB     = mk(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0);

  typedef struct {
    logic [17:0] expected;
    string       name;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          assertions_evaluated = 0;
  int          failures = 0;
  logic [17:0] actual;

  assign actual = {bus.iord_sel, bus.alusrca_sel, bus.alusrcb_sel, bus.memtoreg_sel,
                   bus.regdst_sel, bus.pcsrc_sel, bus.alu_op, bus.pc_write,
                   bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_read,
                   bus.mem_write, bus.illegal_op, bus.idle};

  task automatic checkOutput(input sb_entry_t e);
    assertions_evaluated++;
    if (actual !== e.expected) begin
      failures++;
      $display("[TB] FAIL %s: got %05h expected %05h", e.name, actual, e.expected);
    end
  endtask

  // Monitor: compares mid-cycle, after the stimulus for that cycle has settled.
  always @(negedge clk) begin
    if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
  end

  // Drives one cycle of inputs, queues the expected outputs and advances past the next edge.
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic rdy,
                               input logic [17:0] exp_vec, input string nm);
    sb_entry_t e;
    bus.run       = r;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    e.expected    = exp_vec;
    e.name        = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 6'h00, 0, E_IDLE, "reset_idle_0");
    applyStimulus(1, 6'h00, 1, E_IDLE, "reset_idle_1");
    reset_n = 1'b1;
    applyStimulus(0, 6'h00, 1, E_IDLE, "idle_hold_run0");

    $display("[TB] R-type");
    applyStimulus(1, 6'h00, 1, E_IDLE,     "t1_idle_run");
    applyStimulus(1, 6'h00, 1, E_FETCH_GO, "t1_fetch");
    applyStimulus(1, 6'h00, 1, E_DECODE,   "t1_decode");
    applyStimulus(1, 6'h00, 1, E_EXEC,     "t1_exec");
    applyStimulus(1, 6'h00, 1, E_RWB,      "t1_rwb");

    $display("[TB] LW with memory stalls");
    applyStimulus(1, 6'h23, 0, E_FETCH_WAIT, "t2_fetch_wait0");
    applyStimulus(1, 6'h23, 0, E_FETCH_WAIT, "t2_fetch_wait1");
    applyStimulus(1, 6'h23, 0, E_FETCH_WAIT, "t2_fetch_wait2");
    applyStimulus(1, 6'h23, 1, E_FETCH_GO,   "t2_fetch_go");
    applyStimulus(1, 6'h23, 0, E_DECODE,     "t2_decode");
    applyStimulus(1, 6'h23, 1, E_MEMADR,     "t2_memadr");
    applyStimulus(1, 6'h23, 0, E_MEMRD,      "t2_memrd_wait0");
    applyStimulus(1, 6'h23, 0, E_MEMRD,      "t2_memrd_wait1");
    applyStimulus(1, 6'h23, 1, E_MEMRD,      "t2_memrd_go");
    applyStimulus(1, 6'h23, 1, E_MEMWB,      "t2_memwb");

    $display("[TB] BEQ and J");
    applyStimulus(1, 6'h04, 1, E_FETCH_GO, "t3_beq_fetch");
    applyStimulus(1, 6'h04, 1, E_DECODE,   "t3_beq_decode");
    applyStimulus(1, 6'h04, 1, E_BRANCH,   "t3_branch");
    applyStimulus(1, 6'h02, 1, E_FETCH_GO, "t3_j_fetch");
    applyStimulus(1, 6'h02, 1, E_DECODE,   "t3_j_decode");
    applyStimulus(1, 6'h02, 1, E_JUMP,     "t3_jump");

    $display("[TB] illegal opcode then ADDI");
    applyStimulus(1, 6'h3F, 1, E_FETCH_GO,   "t4_ill_fetch");
    applyStimulus(1, 6'h3F, 1, E_DECODE_ILL, "t4_ill_decode");
    applyStimulus(1, 6'h3F, 0, E_FETCH_WAIT, "t4_ill_back_to_fetch");
    applyStimulus(1, 6'h08, 1, E_FETCH_GO,   "t4_addi_fetch");
    applyStimulus(1, 6'h08, 1, E_DECODE,     "t4_addi_decode");
    applyStimulus(1, 6'h08, 1, E_ADDIEX,     "t4_addiex");
    applyStimulus(1, 6'h08, 1, E_ADDIWB,     "t4_addiwb");

    $display("[TB] SW with run dropped");
    applyStimulus(1, 6'h2B, 1, E_FETCH_GO, "t5_fetch");
    applyStimulus(1, 6'h2B, 1, E_DECODE,   "t5_decode");
    applyStimulus(1, 6'h2B, 1, E_MEMADR,   "t5_memadr");
    applyStimulus(0, 6'h2B, 0, E_MEMWR,    "t5_memwr_wait0");
    applyStimulus(0, 6'h2B, 0, E_MEMWR,    "t5_memwr_wait1");
    applyStimulus(0, 6'h2B, 1, E_MEMWR,    "t5_memwr_go");
    applyStimulus(0, 6'h2B, 1, E_IDLE,     "t5_idle_0");
    applyStimulus(0, 6'h2B, 1, E_IDLE,     "t5_idle_1");

    $display("[TB] async reset in MEMRD");
    applyStimulus(1, 6'h23, 1, E_IDLE,     "t6_idle_run");
    applyStimulus(1, 6'h23, 1, E_FETCH_GO, "t6_fetch");
    applyStimulus(1, 6'h23, 1, E_DECODE,   "t6_decode");
    applyStimulus(1, 6'h23, 1, E_MEMADR,   "t6_memadr");
    applyStimulus(1, 6'h23, 0, E_MEMRD,    "t6_memrd");
    reset_n = 1'b0;
    applyStimulus(1, 6'h23, 0, E_IDLE,       "t6_reset_in_memrd");
    reset_n = 1'b1;
    applyStimulus(1, 6'h23, 1, E_IDLE,       "t6_idle_after_reset");
    applyStimulus(1, 6'h23, 0, E_FETCH_WAIT, "t6_restart_fetch");

    @(negedge clk);
    assertions_evaluated++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
